// File: rtl/rand_pkg.sv
// Shared constants and helpers for the random-word arbiter.
package rand_pkg;

    localparam int unsigned WORD_W   = 32;
    localparam int unsigned SERVED_W = 16;
    localparam int unsigned FAULTS_W = 8;
    localparam int unsigned STATE_W  = 2;

    typedef logic [STATE_W-1:0] state_t;

    // Encoding 3 is never entered and is decoded as FAULT.
    localparam state_t ST_INIT  = 2'd0;
    localparam state_t ST_SERVE = 2'd1;
    localparam state_t ST_FAULT = 2'd2;

    // Saturating increment for the fault counter.
    function automatic logic [FAULTS_W-1:0] sat_inc_faults(input logic [FAULTS_W-1:0] v);
        return (v == {FAULTS_W{1'b1}}) ? v : v + FAULTS_W'(1);
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first set request at or after ptr wins.
module rr_arbiter #(
    parameter int unsigned N_REQ = 4,
    parameter int unsigned IDX_W = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] req,
    input  logic [IDX_W-1:0] ptr,
    input  logic             enable,
    output logic [N_REQ-1:0] gnt
);

    logic [IDX_W-1:0] idx;
    logic             found;

    // Scan requesters starting at ptr, wrapping at N_REQ.
    always_comb begin
        gnt   = '0;
        idx   = '0;
        found = 1'b0;
        for (int k = 0; k < int'(N_REQ); k++) begin
            idx = IDX_W'((int'(ptr) + k) % int'(N_REQ));
            if (enable && !found && req[idx]) begin
                gnt[idx] = 1'b1;
                found    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/rand_arbiter.sv
// Shares a random-number generator among N_REQ requesters, supervising
// generator start-up and restarting it after self-check faults.
module rand_arbiter
    import rand_pkg::*;
#(
    parameter int          DELAY        = 1,
    parameter int unsigned N_REQ        = 4,
    parameter int unsigned RESTART_CYC  = 16,
    parameter int unsigned INIT_TIMEOUT = 1024
) (
    input  logic                CLK,
    input  logic                RESET,
    input  logic                rng_valid,
    input  logic                rng_error,
    input  logic [WORD_W-1:0]   rng_rand,
    output logic                rng_restart,
    input  logic [N_REQ-1:0]    req,
    output logic [N_REQ-1:0]    gnt,
    output logic [WORD_W-1:0]   rdata,
    output logic [SERVED_W-1:0] served,
    output logic [FAULTS_W-1:0] faults,
    output logic [STATE_W-1:0]  state
);

    localparam int unsigned IDX_W   = $clog2(N_REQ);
    localparam int unsigned CNT_MAX = (INIT_TIMEOUT > RESTART_CYC) ? INIT_TIMEOUT : RESTART_CYC;
    localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);

    // Registers switch with zero delay; DELAY survives only for parameter
    // compatibility with the legacy behavioural model.
    if (DELAY < 0) begin : g_delay_compat
    end

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [IDX_W-1:0]    ptr_q, ptr_d;
    logic [N_REQ-1:0]    gnt_q, gnt_d;
    logic [WORD_W-1:0]   rdata_q, rdata_d;
    logic [SERVED_W-1:0] served_q, served_d;
    logic [FAULTS_W-1:0] faults_q, faults_d;
    logic                restart_q, restart_d;

    logic                arb_en_c;
    logic [N_REQ-1:0]    rr_gnt_c;
    logic [IDX_W-1:0]    gidx;

    assign arb_en_c = (state_q == ST_SERVE) && rng_valid && !rng_error;

    rr_arbiter #(
        .N_REQ (N_REQ),
        .IDX_W (IDX_W)
    ) u_rr (
        .req    (req),
        .ptr    (ptr_q),
        .enable (arb_en_c),
        .gnt    (rr_gnt_c)
    );

    // Next-state, counter and grant logic.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        ptr_d     = ptr_q;
        gnt_d     = '0;
        rdata_d   = rdata_q;
        served_d  = served_q;
        faults_d  = faults_q;
        restart_d = restart_q;
        gidx      = '0;

        for (int j = 0; j < int'(N_REQ); j++) begin
            if (rr_gnt_c[j]) gidx = IDX_W'(j);
        end

        case (state_q)
            ST_INIT: begin
                restart_d = 1'b0;
                if (rng_error || cnt_q == CNT_W'(INIT_TIMEOUT - 1)) begin
                    state_d   = ST_FAULT;
                    cnt_d     = '0;
                    restart_d = 1'b1;
                    faults_d  = sat_inc_faults(faults_q);
                end else if (rng_valid) begin
                    state_d = ST_SERVE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_SERVE: begin
                restart_d = 1'b0;
                if (rng_error) begin
                    state_d   = ST_FAULT;
                    cnt_d     = '0;
                    restart_d = 1'b1;
                    faults_d  = sat_inc_faults(faults_q);
                end else if (|rr_gnt_c) begin
                    gnt_d    = rr_gnt_c;
                    rdata_d  = rng_rand;
                    served_d = served_q + SERVED_W'(1);
                    ptr_d    = (gidx == IDX_W'(N_REQ - 1)) ? '0 : gidx + IDX_W'(1);
                end
            end
            default: begin
                // FAULT (and the unreachable encoding): hold restart for the window.
                restart_d = 1'b1;
                if (cnt_q == CNT_W'(RESTART_CYC - 1)) begin
                    state_d   = ST_INIT;
                    cnt_d     = '0;
                    restart_d = 1'b0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
        endcase
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge CLK) begin
        if (!RESET) begin
            state_q   <= ST_INIT;
            cnt_q     <= '0;
            ptr_q     <= '0;
            gnt_q     <= '0;
            rdata_q   <= '0;
            served_q  <= '0;
            faults_q  <= '0;
            restart_q <= 1'b1;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            ptr_q     <= ptr_d;
            gnt_q     <= gnt_d;
            rdata_q   <= rdata_d;
            served_q  <= served_d;
            faults_q  <= faults_d;
            restart_q <= restart_d;
        end
    end

    assign rng_restart = restart_q;
    assign gnt         = gnt_q;
    assign rdata       = rdata_q;
    assign served      = served_q;
    assign faults      = faults_q;
    assign state       = state_q;

endmodule

// File: tb/tb_rand_arbiter.sv
// Directed, table-driven bench for rand_arbiter with default parameters.
module tb_rand_arbiter;
    import rand_pkg::*;

    logic        CLK = 1'b0;
    logic        RESET;
    logic        rng_valid;
    logic        rng_error;
    logic [31:0] rng_rand;
    logic        rng_restart;
    logic [3:0]  req;
    logic [3:0]  gnt;
    logic [31:0] rdata;
    logic [15:0] served;
    logic [7:0]  faults;
    logic [1:0]  state;

    int n_checks = 0;
    int n_pass   = 0;

    rand_arbiter dut (
        .CLK         (CLK),
        .RESET       (RESET),
        .rng_valid   (rng_valid),
        .rng_error   (rng_error),
        .rng_rand    (rng_rand),
        .rng_restart (rng_restart),
        .req         (req),
        .gnt         (gnt),
        .rdata       (rdata),
        .served      (served),
        .faults      (faults),
        .state       (state)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic [3:0]  req;
        logic        valid;
        logic [31:0] rnd;
        logic [3:0]  exp_gnt;
        logic [31:0] exp_rdata;
        logic [15:0] exp_served;
    } vec_t;

    vec_t vecs [15];

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp)
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        else
            n_pass++;
    endtask

    initial begin
        int n;
        int gnt_seen;

        RESET = 1'b0; rng_valid = 1'b0; rng_error = 1'b0; rng_rand = '0; req = '0;

        // Pointer starts at requester 0 and moves past each winner.
        vecs[0]  = '{4'b1111, 1'b1, 32'h0000_00A0, 4'b0001, 32'h0000_00A0, 16'd1};
        vecs[1]  = '{4'b1111, 1'b1, 32'h0000_00A1, 4'b0010, 32'h0000_00A1, 16'd2};
        vecs[2]  = '{4'b1111, 1'b1, 32'h0000_00A2, 4'b0100, 32'h0000_00A2, 16'd3};
        vecs[3]  = '{4'b1111, 1'b1, 32'h0000_00A3, 4'b1000, 32'h0000_00A3, 16'd4};
        vecs[4]  = '{4'b1111, 1'b1, 32'h0000_00A4, 4'b0001, 32'h0000_00A4, 16'd5};
        vecs[5]  = '{4'b0100, 1'b1, 32'hDEAD_BEEF, 4'b0100, 32'hDEAD_BEEF, 16'd6};
        vecs[6]  = '{4'b0100, 1'b0, 32'h1234_5678, 4'b0000, 32'hDEAD_BEEF, 16'd6};
        vecs[7]  = '{4'b0100, 1'b1, 32'h1111_1111, 4'b0100, 32'h1111_1111, 16'd7};
        vecs[8]  = '{4'b0000, 1'b1, 32'h2222_2222, 4'b0000, 32'h1111_1111, 16'd7};
        vecs[9]  = '{4'b0101, 1'b1, 32'h3333_3333, 4'b0001, 32'h3333_3333, 16'd8};
        vecs[10] = '{4'b0101, 1'b1, 32'h4444_4444, 4'b0100, 32'h4444_4444, 16'd9};
        vecs[11] = '{4'b0101, 1'b1, 32'h5555_5555, 4'b0001, 32'h5555_5555, 16'd10};
        vecs[12] = '{4'b1010, 1'b1, 32'h6666_6666, 4'b0010, 32'h6666_6666, 16'd11};
        vecs[13] = '{4'b1010, 1'b1, 32'h7777_7777, 4'b1000, 32'h7777_7777, 16'd12};
        vecs[14] = '{4'b1010, 1'b1, 32'h8888_8888, 4'b0010, 32'h8888_8888, 16'd13};

        // Reset values
        step(); step();
        chk("rst_state",   32'(state),       32'(ST_INIT));
        chk("rst_gnt",     32'(gnt),         32'h0);
        chk("rst_rdata",   rdata,            32'h0);
        chk("rst_restart", 32'(rng_restart), 32'h1);
        chk("rst_served",  32'(served),      32'h0);
        chk("rst_faults",  32'(faults),      32'h0);

        // Release, generator valid on cycle 3
        RESET = 1'b1;
        step();
        chk("rel_restart", 32'(rng_restart), 32'h0);
        chk("rel_state",   32'(state),       32'(ST_INIT));
        step();
        rng_valid = 1'b1;
        step();
        chk("init_to_serve", 32'(state), 32'(ST_SERVE));
        chk("init_no_gnt",   32'(gnt),   32'h0);

        // Table-driven grant vectors
        for (int i = 0; i < 15; i++) begin
            req = vecs[i].req; rng_valid = vecs[i].valid; rng_rand = vecs[i].rnd;
            step();
            chk($sformatf("vec%0d_gnt", i),    32'(gnt),    32'(vecs[i].exp_gnt));
            chk($sformatf("vec%0d_rdata", i),  rdata,       vecs[i].exp_rdata);
            chk($sformatf("vec%0d_served", i), 32'(served), 32'(vecs[i].exp_served));
            chk($sformatf("vec%0d_state", i),  32'(state),  32'(ST_SERVE));
        end

        // Error pulse in SERVE: restart window of 16, error mid-window ignored
        req = 4'b1111; rng_valid = 1'b1; rng_rand = 32'h0000_0099; rng_error = 1'b1;
        step();
        chk("err_state",   32'(state),       32'(ST_FAULT));
        chk("err_gnt",     32'(gnt),         32'h0);
        chk("err_restart", 32'(rng_restart), 32'h1);
        chk("err_faults",  32'(faults),      32'h1);
        chk("err_served",  32'(served),      32'd13);
        n = 1; gnt_seen = 0;
        for (int i = 0; i < 40 && rng_restart; i++) begin
            rng_error = (i == 4);
            step();
            if (gnt != 4'b0000) gnt_seen++;
            if (rng_restart) n++;
        end
        rng_error = 1'b0;
        chk("restart_width",  32'(n),        32'd16);
        chk("window_no_gnt",  32'(gnt_seen), 32'd0);
        chk("window_to_init", 32'(state),    32'(ST_INIT));
        chk("window_faults",  32'(faults),   32'h1);
        step();
        chk("reinit_serve", 32'(state), 32'(ST_SERVE));
        step();
        chk("ptr_kept_gnt",   32'(gnt),    32'b0100);
        chk("ptr_kept_rdata", rdata,       32'h0000_0099);
        chk("ptr_kept_srv",   32'(served), 32'd14);

        // Reset during FAULT window
        rng_error = 1'b1;
        step();
        chk("f2_faults", 32'(faults), 32'h2);
        rng_error = 1'b0;
        repeat (4) step();
        RESET = 1'b0;
        step();
        chk("midf_state",   32'(state),       32'(ST_INIT));
        chk("midf_faults",  32'(faults),      32'h0);
        chk("midf_restart", 32'(rng_restart), 32'h1);
        chk("midf_served",  32'(served),      32'h0);
        chk("midf_rdata",   rdata,            32'h0);
        step();
        chk("midf_restart_hold", 32'(rng_restart), 32'h1);
        RESET = 1'b1;
        step();
        chk("midf_rel_restart", 32'(rng_restart), 32'h0);
        chk("midf_rel_gnt",     32'(gnt),         32'h0);
        chk("midf_rel_state",   32'(state),       32'(ST_SERVE));
        step();
        chk("midf_ptr_reset", 32'(gnt), 32'b0001);

        // Init timeout
        RESET = 1'b0; rng_valid = 1'b0; req = '0;
        step();
        RESET = 1'b1;
        n = 0;
        for (int i = 0; i < 2000; i++) begin
            step();
            n++;
            if (state == ST_FAULT) break;
        end
        chk("timeout_cycles", 32'(n),      32'd1024);
        chk("timeout_faults", 32'(faults), 32'h1);

        // Error held: one fault per 17 cycles, then saturation
        rng_error = 1'b1;
        repeat (170) step();
        chk("faults_after_10", 32'(faults), 32'd11);
        repeat (17 * 300) step();
        chk("faults_sat", 32'(faults), 32'hFF);
        rng_error = 1'b0;

        // served wraps after 65536 grants
        RESET = 1'b0;
        step();
        RESET = 1'b1; rng_valid = 1'b1; req = 4'b0001; rng_rand = 32'hCAFE_F00D;
        step();
        repeat (65535) step();
        chk("served_max",  32'(served), 32'hFFFF);
        step();
        chk("served_wrap", 32'(served), 32'h0);
        chk("wrap_gnt",    32'(gnt),    32'b0001);
        chk("wrap_rdata",  rdata,       32'hCAFE_F00D);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/rand_arbiter.md
RAND_ARBITER -- requirements
Module: rand_arbiter

Interface
REQ-001 Parameter DELAY, default 1, intra-assignment delay on every registered output.
REQ-002 Parameter N_REQ, default 4, number of requesters (2..8).
REQ-003 Parameter RESTART_CYC, default 16, cycles the generator restart is held.
REQ-004 Parameter INIT_TIMEOUT, default 1024, cycles allowed for the generator to become valid.
REQ-005 CLK  in  1  single clock, all logic on rising edge.
REQ-006 RESET  in  1  synchronous, active-low reset.
REQ-007 rng_valid  in  1  generator output word valid.
REQ-008 rng_error  in  1  generator self-check failure.
REQ-009 rng_rand  in  32  generator output word.
REQ-010 rng_restart  out  1  active-high reset to the generator.
REQ-011 req  in  N_REQ  level request, one bit per requester.
REQ-012 gnt  out  N_REQ  one-hot grant pulse qualifying rdata.
REQ-013 rdata  out  32  random word delivered with gnt.
REQ-014 served  out  16  count of words delivered.
REQ-015 faults  out  8  count of generator faults.
REQ-016 state  out  2  current state encoding for status LEDs.

Function
REQ-017 States are INIT=0, SERVE=1, FAULT=2; encoding 3 is unreachable and decodes to FAULT.
REQ-018 INIT: counts cycles; on rng_valid=1 and rng_error=0, go to SERVE; when the count reaches INIT_TIMEOUT-1, go to FAULT.
REQ-019 SERVE: each cycle with rng_valid=1, rng_error=0 and req nonzero, grant exactly one requester, round-robin starting at the index after the last grant.
REQ-020 Grant latency is 1 cycle: gnt and rdata register on the edge following the cycle in which req and rng_rand are sampled; rdata equals the rng_rand sampled in that cycle.
REQ-021 gnt is all-zero in any cycle without a grant; rdata holds its last value when gnt is zero.
REQ-022 Each generator word is delivered at most once; unrequested words are discarded.
REQ-023 A requester holding req receives consecutive words only when no other req bit is set.
REQ-024 SERVE with rng_valid=0 and rng_error=0: no grant, remain in SERVE.
REQ-025 rng_error=1 in SERVE or INIT: go to FAULT next cycle, no grant issued that cycle, faults increments.
REQ-026 FAULT: rng_restart=1 for exactly RESTART_CYC cycles, then deassert and go to INIT with the timeout counter cleared.
REQ-027 An INIT timeout increments faults exactly like rng_error does.
REQ-028 rng_error asserted during FAULT is ignored; the restart window is not extended.
REQ-029 served increments by 1 per grant and wraps from 0xFFFF to 0.
REQ-030 faults saturates at 0xFF.
REQ-031 The round-robin pointer is preserved across FAULT/INIT; it is cleared only by reset.

Reset
REQ-032 RESET=0 at a rising edge sets: state INIT, gnt 0, rdata 0, rng_restart 1, served 0, faults 0, counters 0, and the pointer such that requester 0 has highest priority.
REQ-033 rng_restart stays 1 while RESET=0 and drops on the first edge with RESET=1.
REQ-034 Reset asserted mid-grant or mid-FAULT aborts immediately; no grant pulse follows reset release until SERVE is re-entered.

Structure
REQ-035 Package rand_pkg holds the state enum, the 32-bit word width, and the counter widths for served and faults.
REQ-036 Round-robin selection is one sub-module rr_arbiter (inputs req, pointer, enable; output one-hot gnt) reused elsewhere; the FSM and counters stay in rand_arbiter.

Verification
REQ-037 Reset release, rng_valid=1 at cycle 3 -> state SERVE at cycle 4; rng_restart 0 from cycle 1.
REQ-038 req=4'b1111 held, rng_valid=1 continuous -> gnt sequence 0001,0010,0100,1000,0001; rdata equals the rng_rand of the prior cycle; served=5.
REQ-039 req=4'b0100 only, rng_rand=0xDEADBEEF -> next cycle gnt=0100, rdata=0xDEADBEEF; with rng_valid=0 -> gnt=0.
REQ-040 rng_error pulse in SERVE -> state FAULT next cycle, rng_restart high exactly 16 cycles, then INIT, faults=1, no gnt during the window.
REQ-041 rng_valid never asserted after reset -> FAULT after 1024 cycles, faults=1; repeat 300 times -> faults saturates at 0xFF.
REQ-042 RESET=0 during FAULT at cycle 5 of the window -> state INIT, faults=0, rng_restart held until release.
